cam_tft_stream_bridge: RTL and testbench
========================================

CAM_TFT_STREAM_BRIDGE -- requirements
Module: cam_tft_stream_bridge

Interface
REQ-001 SHALL have parameter FRAME_W, 320, active pixels per line.
REQ-002 SHALL have parameter FRAME_H, 240, active lines per frame.
REQ-003 SHALL have parameter BYTES_PER_PIX, 2, camera bytes per pixel (1 or 2).
REQ-004 SHALL have parameter DECIM, 1, keep every DECIM-th pixel and line (1, 2 or 4).
REQ-005 SHALL have parameter FIFO_DEPTH, 16, pixel FIFO entries (power of two, at least 4).
REQ-006 SHALL have port clk  input  1  system clock.
REQ-007 SHALL have port buttonReset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports vsync, href, pclk  input  1 each  raw camera timing, asynchronous to clk.
REQ-009 SHALL have port cam_data  input  8  camera byte bus.
REQ-010 SHALL have port pix_data  output  8*BYTES_PER_PIX  assembled pixel; first camera byte in the MSBs.
REQ-011 SHALL have ports pix_valid (output, 1) and pix_ready (input, 1)  downstream valid/ready handshake.
REQ-012 SHALL have port frame_start  output  1  one-clk strobe at the start of each frame.
REQ-013 SHALL have ports overflow and size_err  output  1 each  sticky error flags.
REQ-014 SHALL have port err_clear  input  1  clears both sticky flags.

Function
REQ-015 SHALL pass vsync, href and pclk through two-flop synchronisers, plus one history flop on pclk.
REQ-016 SHALL detect a pclk rising edge as sync=1, history=0.
REQ-017 SHALL sample cam_data only on a detected pclk edge while synchronised href=1, using cam_data delayed by the same two stages.
REQ-018 SHALL run FSM states WAIT_FRAME, WAIT_LINE, CAPTURE, LINE_END, with the following transitions:
- WAIT_FRAME -> WAIT_LINE on a synchronised vsync falling edge.
- WAIT_LINE -> CAPTURE on an href rising edge.
- CAPTURE -> LINE_END on an href falling edge.
- LINE_END -> WAIT_LINE if row < FRAME_H-1, else -> WAIT_FRAME.
REQ-019 SHALL assert frame_start for exactly one clk on the WAIT_FRAME -> WAIT_LINE transition, and SHALL reset col, row and the byte phase at that point.
REQ-020 SHALL assemble BYTES_PER_PIX bytes per pixel using a byte-phase counter that resets at every href rising edge.
REQ-021 SHALL push a completed pixel into the FIFO only when col%DECIM==0 and row%DECIM==0.
REQ-022 SHALL wrap col to 0 and increment row at each href falling edge.
REQ-023 SHALL set size_err if, at an href falling edge, the pixel count for that line != FRAME_W, or if a vsync rising edge occurs while row != FRAME_H.
REQ-024 SHALL, from a vsync rising edge in any state other than WAIT_FRAME, abort the frame: return to WAIT_FRAME and flush the FIFO.
REQ-025 SHALL, on a push while the FIFO is full, drop the pixel, set overflow and leave the FIFO unchanged.
REQ-026 SHALL, on a simultaneous push and pop when full, accept the push.
REQ-027 SHALL, on a simultaneous push and pop when empty, not forward the pushed pixel in the same cycle.
REQ-028 SHALL drive pix_valid = FIFO not empty and pix_data = FIFO head; a pop occurs on pix_valid & pix_ready.
REQ-029 SHALL keep pix_data stable while pix_valid=1 and pix_ready=0.
REQ-030 SHALL have a latency of 1 clk from the internal push to pix_valid=1 when the FIFO was empty.
REQ-031 SHALL clear overflow and size_err on err_clear; if a set and err_clear occur in the same cycle, set wins.

Reset
REQ-032 SHALL, on buttonReset, immediately force the following, independent of clk:
- FSM to WAIT_FRAME.
- Counters, synchronisers and FIFO pointers to 0.
- pix_valid=0, pix_data=0, frame_start=0, overflow=0, size_err=0.
REQ-033 SHALL, when reset deasserts mid-frame, ignore data until the next vsync falling edge.

Configuration
REQ-034 SHALL, with CAM_STREAM_TEST_PATTERN_EN defined, replace the sampled bytes with an 8-bar pattern: bar index = col*8/FRAME_W; pixel = {BYTES_PER_PIX{bar index replicated into the byte}}. Camera timing is still used.
REQ-035 SHALL, without CAM_STREAM_TEST_PATTERN_EN, carry no pattern logic and pass camera data only.

Structure
REQ-036 SHALL place the FSM state enum, the synchroniser depth constant (2) and the FRAME_W/FRAME_H defaults in package cam_stream_pkg.
REQ-037 SHALL implement the FIFO as sub-module cam_stream_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, flush).

Verification
REQ-038 SHALL cover a 4x2 frame with BYTES_PER_PIX=2, bytes 0x01..0x10 and pix_ready=1 -> 8 pixels 0x0102, 0x0304 ... 0x0F10, one frame_start, size_err=0.
REQ-039 SHALL cover DECIM=2 on a 4x4 frame with BYTES_PER_PIX=1 and bytes 0..15 -> pixels 0, 2, 8, 10 only.
REQ-040 SHALL cover FIFO_DEPTH=4 with pix_ready=0 and 6 pixels -> 4 held, overflow=1; after pix_ready=1, the first 4 pixels come out in order.
REQ-041 SHALL cover a line of 3 pixels with FRAME_W=4 -> size_err=1; err_clear -> 0.
REQ-042 SHALL cover a vsync rising edge mid-line with 2 pixels queued -> FIFO flushed, pix_valid=0 next clk, FSM in WAIT_FRAME.
REQ-043 SHALL cover buttonReset asserted mid-frame -> all outputs 0 asynchronously, and no pixels until the next vsync falling edge.

Source files
------------

// File: rtl/cam_stream_pkg.sv
// Shared types and constants for the camera-to-TFT pixel stream bridge.
package cam_stream_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    CAPTURE    = 2'd2,
    LINE_END   = 2'd3
  } cam_state_e;

  localparam int SYNC_STAGES = 2;
  localparam int DEF_FRAME_W = 320;
  localparam int DEF_FRAME_H = 240;

endpackage

// File: rtl/cam_stream_fifo.sv
// Pixel FIFO: power-of-two depth, wrap-bit pointers, zero head when empty.
module cam_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             buttonReset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cam_tft_stream_bridge.sv
// Camera (vsync/href/pclk) to valid/ready pixel stream bridge.
// Define CAM_STREAM_TEST_PATTERN_EN to replace camera bytes with 8 colour bars.
//
// state      | meaning
// WAIT_FRAME | idle until synchronised vsync falls
// WAIT_LINE  | inside a frame, waiting for href to rise
// CAPTURE    | href high, assembling and pushing pixels
// LINE_END   | one cycle to decide next line or end of frame
module cam_tft_stream_bridge
  import cam_stream_pkg::*;
#(
  parameter int FRAME_W       = DEF_FRAME_W,
  parameter int FRAME_H       = DEF_FRAME_H,
  parameter int BYTES_PER_PIX = 2,
  parameter int DECIM         = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         buttonReset,
  input  logic                         vsync,
  input  logic                         href,
  input  logic                         pclk,
  input  logic [7:0]                   cam_data,
  output logic [8*BYTES_PER_PIX-1:0]   pix_data,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic                         frame_start,
  output logic                         overflow,
  output logic                         size_err,
  input  logic                         err_clear
);

  localparam int PIX_W = 8 * BYTES_PER_PIX;
  localparam int COL_W = $clog2(FRAME_W + 1);
  localparam int ROW_W = $clog2(FRAME_H + 1);

  logic [SYNC_STAGES-1:0]      vsync_sync_q, href_sync_q, pclk_sync_q;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q;
  logic                        vsync_hist_q, href_hist_q, pclk_hist_q;
  logic                        vs_s, hr_s, pc_s, vs_rise, vs_fall, hr_rise, hr_fall, pclk_edge;
  logic [7:0]                  byte_in;

  cam_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       phase_q, phase_d;
  logic [PIX_W-1:0] asm_q, asm_d;
  logic             active_q, active_d, overflow_q, overflow_d, size_err_q, size_err_d;

  logic             abort_w, sample_w, pix_done_w, keep_w, push_w, pop_w, line_end_w;
  logic [PIX_W+7:0] asm_next;
  logic [PIX_W-1:0] pix_w;
  logic             fifo_full, fifo_empty;

  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) begin
      vsync_sync_q <= '0;
      href_sync_q  <= '0;
      pclk_sync_q  <= '0;
      data_sync_q  <= '0;
      vsync_hist_q <= 1'b0;
      href_hist_q  <= 1'b0;
      pclk_hist_q  <= 1'b0;
    end else begin
      vsync_sync_q <= {vsync_sync_q[SYNC_STAGES-2:0], vsync};
      href_sync_q  <= {href_sync_q[SYNC_STAGES-2:0], href};
      pclk_sync_q  <= {pclk_sync_q[SYNC_STAGES-2:0], pclk};
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], cam_data};
      vsync_hist_q <= vs_s;
      href_hist_q  <= hr_s;
      pclk_hist_q  <= pc_s;
    end
  end

  assign vs_s      = vsync_sync_q[SYNC_STAGES-1];
  assign hr_s      = href_sync_q[SYNC_STAGES-1];
  assign pc_s      = pclk_sync_q[SYNC_STAGES-1];
  assign byte_in   = data_sync_q[SYNC_STAGES-1];
  assign vs_rise   = vs_s & ~vsync_hist_q;
  assign vs_fall   = ~vs_s & vsync_hist_q;
  assign hr_rise   = hr_s & ~href_hist_q;
  assign hr_fall   = ~hr_s & href_hist_q;
  assign pclk_edge = pc_s & ~pclk_hist_q;

  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) state_q <= WAIT_FRAME;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_w) begin
      state_d = WAIT_FRAME;
    end else begin
      case (state_q)
        WAIT_FRAME: if (vs_fall) state_d = WAIT_LINE;
        WAIT_LINE:  if (hr_rise) state_d = CAPTURE;
        CAPTURE:    if (hr_fall) state_d = LINE_END;
        // row already counts the line that just finished
        LINE_END:   state_d = (row_q < ROW_W'(FRAME_H)) ? WAIT_LINE : WAIT_FRAME;
        default:    state_d = WAIT_FRAME;
      endcase
    end
  end

  always_comb begin
    abort_w     = vs_rise && (state_q != WAIT_FRAME);
    frame_start = (state_q == WAIT_FRAME) && vs_fall;
    sample_w    = (state_q == CAPTURE) && pclk_edge && hr_s;
    pix_done_w  = sample_w && (phase_q == 2'(BYTES_PER_PIX - 1));
    keep_w      = ((int'(col_q) % DECIM) == 0) && ((int'(row_q) % DECIM) == 0);
    push_w      = pix_done_w && keep_w && !abort_w;
    line_end_w  = (state_q == CAPTURE) && hr_fall;
  end

  assign asm_next = {asm_q, byte_in};

`ifdef CAM_STREAM_TEST_PATTERN_EN
  logic [2:0] bar_w;
  logic [7:0] pat_byte_w;
  assign bar_w      = 3'((int'(col_q) * 8) / FRAME_W);
  assign pat_byte_w = {bar_w, bar_w, bar_w[2:1]};
  assign pix_w      = {BYTES_PER_PIX{pat_byte_w}};
`else
  assign pix_w = asm_next[PIX_W-1:0];
`endif

  assign pop_w = pix_valid & pix_ready;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    phase_d    = phase_q;
    asm_d      = asm_q;
    active_d   = active_q;
    overflow_d = overflow_q;
    size_err_d = size_err_q;
    if (err_clear) begin
      overflow_d = 1'b0;
      size_err_d = 1'b0;
    end
    if (frame_start) begin
      col_d    = '0;
      row_d    = '0;
      phase_d  = '0;
      active_d = 1'b1;
    end
    if ((state_q == WAIT_LINE) && hr_rise) phase_d = '0;
    if (sample_w) begin
      asm_d   = asm_next[PIX_W-1:0];
      phase_d = pix_done_w ? 2'd0 : phase_q + 2'd1;
      if (pix_done_w) col_d = col_q + 1'b1;
    end
    if (line_end_w) begin
      col_d = '0;
      row_d = row_q + 1'b1;
      if (int'(col_q) != FRAME_W) size_err_d = 1'b1;
    end
    if (vs_rise) begin
      active_d = 1'b0;
      if (active_q && (int'(row_q) != FRAME_H)) size_err_d = 1'b1;
    end
    if (push_w && fifo_full && !pop_w) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge buttonReset) begin
    if (buttonReset) begin
      col_q      <= '0;
      row_q      <= '0;
      phase_q    <= '0;
      asm_q      <= '0;
      active_q   <= 1'b0;
      overflow_q <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      phase_q    <= phase_d;
      asm_q      <= asm_d;
      active_q   <= active_d;
      overflow_q <= overflow_d;
      size_err_q <= size_err_d;
    end
  end

  cam_stream_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .buttonReset (buttonReset),
    .push        (push_w),
    .pop         (pop_w),
    .flush       (abort_w),
    .din         (pix_w),
    .dout        (pix_data),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign pix_valid = ~fifo_empty;
  assign overflow  = overflow_q;
  assign size_err  = size_err_q;

endmodule

// File: tb/tb_cam_tft_stream_bridge.sv
// Bench for cam_tft_stream_bridge: two small configurations, table vectors, corner sequences, random frames.
module tb_cam_tft_stream_bridge;
  import cam_stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       buttonReset, vsync, href, pclk, err_clear;
  logic [7:0] cam_data;
  int         sel;
  bit         rnd_ready, man_ready;
  logic       ready_a = 1'b1, ready_b = 1'b1;

  logic        vsync_a, href_a, pclk_a, vsync_b, href_b, pclk_b;
  logic [7:0]  data_a, data_b;
  logic [15:0] pix_data_a;
  logic [7:0]  pix_data_b;
  logic        pix_valid_a, frame_start_a, overflow_a, size_err_a;
  logic        pix_valid_b, frame_start_b, overflow_b, size_err_b;

  assign vsync_a = (sel == 0) ? vsync : 1'b1;
  assign href_a  = (sel == 0) ? href : 1'b0;
  assign pclk_a  = (sel == 0) ? pclk : 1'b0;
  assign data_a  = (sel == 0) ? cam_data : 8'h00;
  assign vsync_b = (sel == 1) ? vsync : 1'b1;
  assign href_b  = (sel == 1) ? href : 1'b0;
  assign pclk_b  = (sel == 1) ? pclk : 1'b0;
  assign data_b  = (sel == 1) ? cam_data : 8'h00;

  cam_tft_stream_bridge #(.FRAME_W(4), .FRAME_H(2), .BYTES_PER_PIX(2), .DECIM(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .buttonReset(buttonReset), .vsync(vsync_a), .href(href_a), .pclk(pclk_a),
    .cam_data(data_a), .pix_data(pix_data_a), .pix_valid(pix_valid_a), .pix_ready(ready_a),
    .frame_start(frame_start_a), .overflow(overflow_a), .size_err(size_err_a), .err_clear(err_clear));

  cam_tft_stream_bridge #(.FRAME_W(4), .FRAME_H(4), .BYTES_PER_PIX(1), .DECIM(2), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .buttonReset(buttonReset), .vsync(vsync_b), .href(href_b), .pclk(pclk_b),
    .cam_data(data_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(ready_b),
    .frame_start(frame_start_b), .overflow(overflow_b), .size_err(size_err_b), .err_clear(err_clear));

  always @(posedge clk) begin
    #2;
    ready_a = (sel == 0) ? (rnd_ready ? ($urandom_range(0, 3) != 0) : man_ready) : 1'b1;
    ready_b = (sel == 1) ? (rnd_ready ? ($urandom_range(0, 3) != 0) : man_ready) : 1'b1;
  end

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  byte_q[$];
  int          fs_cnt;
  int          errors = 0, checks = 0;
  int          lens[4];

  always @(negedge clk) begin
    if (sel == 0 && pix_valid_a && ready_a) got_q.push_back(pix_data_a);
    if (sel == 1 && pix_valid_b && ready_b) got_q.push_back({8'h00, pix_data_b});
    if ((sel == 0 && frame_start_a) || (sel == 1 && frame_start_b)) fs_cnt++;
  end

  typedef struct {
    int nl;
    int l0, l1, l2;
    bit err;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: pixels are consecutive BPP-byte groups per line; kept only on
  // lines of the frame whose column and row are multiples of decim.
  task automatic make_frame(input int nl, input int bpp, input int fh, input int decim,
                            input bit rnd, input int start);
    int k = start;
    byte_q.delete();
    exp_q.delete();
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        int pix = 0;
        for (int b = 0; b < bpp; b++) begin
          int v = rnd ? int'($urandom_range(0, 255)) : (k % 256);
          k++;
          byte_q.push_back(8'(v));
          pix = pix * 256 + v;
        end
        if (l < fh && p % decim == 0 && l % decim == 0) exp_q.push_back(16'(pix));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    cam_data = v;
    #40 pclk = 1'b1;
    #40 pclk = 1'b0;
  endtask

  task automatic send_frame(input int nl, input int bpp);
    vsync = 1'b0;
    #80;
    for (int l = 0; l < nl; l++) begin
      href = 1'b1;
      #40;
      for (int i = 0; i < lens[l] * bpp; i++) send_byte(byte_q.pop_front());
      #40 href = 1'b0;
      #80;
    end
    vsync = 1'b1;
    #80;
  endtask

  task automatic wait_count(input int n);
    for (int i = 0; i < 400 && got_q.size() < n; i++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic compare_frame(input string name);
    check({name, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, " pixel"}, got_q[i], exp_q[i]);
  endtask

  task automatic pulse_clear();
    @(posedge clk) #1 err_clear = 1'b1;
    @(posedge clk) #1 err_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_bench();
    got_q.delete();
    fs_cnt = 0;
  endtask

  int t;

  initial begin
    tbl[0] = '{2, 4, 4, 0, 1'b0};
    tbl[1] = '{2, 3, 4, 0, 1'b1};
    tbl[2] = '{2, 4, 5, 0, 1'b1};
    tbl[3] = '{3, 4, 4, 4, 1'b0};
    tbl[4] = '{1, 4, 0, 0, 1'b1};

    buttonReset = 1'b1; vsync = 1'b1; href = 1'b0; pclk = 1'b0; cam_data = 8'h00;
    err_clear = 1'b0; sel = 0; rnd_ready = 1'b0; man_ready = 1'b1; fs_cnt = 0;
    #23;
    check("reset pix_valid", pix_valid_a, 1'b0);
    check("reset pix_data", pix_data_a, 16'h0);
    check("reset frame_start", frame_start_a, 1'b0);
    check("reset overflow", overflow_a, 1'b0);
    check("reset size_err", size_err_a, 1'b0);
    #9 buttonReset = 1'b0;
    repeat (5) @(negedge clk);

    for (int e = 0; e < 5; e++) begin
      pulse_clear();
      reset_bench();
      lens[0] = tbl[e].l0; lens[1] = tbl[e].l1; lens[2] = tbl[e].l2; lens[3] = 0;
      make_frame(tbl[e].nl, 2, 2, 1, 1'b0, 1);
      send_frame(tbl[e].nl, 2);
      wait_count(exp_q.size());
      compare_frame($sformatf("vec%0d", e));
      check($sformatf("vec%0d size_err", e), size_err_a, tbl[e].err);
      check($sformatf("vec%0d frame_start", e), fs_cnt, 1);
      check($sformatf("vec%0d overflow", e), overflow_a, 1'b0);
      if (e == 0) begin
        check("4x2 first pixel", got_q.size() > 0 ? got_q[0] : 16'hxxxx, 16'h0102);
        check("4x2 last pixel", got_q.size() > 7 ? got_q[7] : 16'hxxxx, 16'h0F10);
      end
      if (tbl[e].err) begin
        pulse_clear();
        check($sformatf("vec%0d err_clear", e), size_err_a, 1'b0);
      end
    end

    // FIFO fills with ready low: four held, the rest dropped
    pulse_clear();
    reset_bench();
    man_ready = 1'b0;
    lens[0] = 4; lens[1] = 2;
    make_frame(2, 2, 2, 1, 1'b0, 1);
    send_frame(2, 2);
    check("full count", got_q.size(), 0);
    check("full pix_valid", pix_valid_a, 1'b1);
    check("full overflow", overflow_a, 1'b1);
    repeat (10) @(negedge clk);
    check("held pix_data", pix_data_a, 16'h0102);
    man_ready = 1'b1;
    wait_count(4);
    check("drain count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("drain pixel", got_q[i], exp_q[i]);
    check("drain pix_valid", pix_valid_a, 1'b0);

    // vsync rising mid-line flushes the queue
    pulse_clear();
    reset_bench();
    man_ready = 1'b0;
    vsync = 1'b0; #80;
    href = 1'b1; #40;
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    #80;
    check("abort pre pix_valid", pix_valid_a, 1'b1);
    vsync = 1'b1;
    t = 0;
    while (pix_valid_a && t < 8) begin @(negedge clk); t++; end
    check("abort flushed", pix_valid_a, 1'b0);
    check("abort latency ok", t <= 4, 1'b1);
    check("abort state", 32'(dut_a.state_q), 32'(WAIT_FRAME));
    man_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send_byte(8'(i));
    #40 href = 1'b0;
    repeat (20) @(negedge clk);
    check("abort no pixels", got_q.size(), 0);

    // asynchronous reset mid-frame, then nothing until the next frame
    pulse_clear();
    reset_bench();
    man_ready = 1'b0;
    vsync = 1'b0; #80;
    href = 1'b1; #40;
    for (int i = 0; i < 12; i++) send_byte(8'(8'h40 + i));
    #40;
    check("prereset overflow", overflow_a, 1'b1);
    check("prereset pix_valid", pix_valid_a, 1'b1);
    #3 buttonReset = 1'b1;
    #1;
    check("async rst pix_valid", pix_valid_a, 1'b0);
    check("async rst pix_data", pix_data_a, 16'h0);
    check("async rst overflow", overflow_a, 1'b0);
    check("async rst size_err", size_err_a, 1'b0);
    check("async rst frame_start", frame_start_a, 1'b0);
    #16 buttonReset = 1'b0;
    man_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'h77);
    #40 href = 1'b0; #80;
    href = 1'b1; #40;
    for (int i = 0; i < 8; i++) send_byte(8'h66);
    #40 href = 1'b0; #80;
    vsync = 1'b1; #80;
    repeat (20) @(negedge clk);
    check("post reset ignored", got_q.size(), 0);
    lens[0] = 4; lens[1] = 4;
    make_frame(2, 2, 2, 1, 1'b0, 8'h21);
    send_frame(2, 2);
    wait_count(exp_q.size());
    compare_frame("post reset frame");
    check("post reset size_err", size_err_a, 1'b0);

    // random frames against the reference model
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      reset_bench();
      lens[0] = 4; lens[1] = 4;
      make_frame(2, 2, 2, 1, 1'b1, 0);
      send_frame(2, 2);
      wait_count(exp_q.size());
      compare_frame("rand a");
    end
    check("rand a overflow", overflow_a, 1'b0);
    check("rand a size_err", size_err_a, 1'b0);

    // decimation by 2 on a 4x4 single-byte frame
    rnd_ready = 1'b0;
    sel = 1;
    repeat (5) @(negedge clk);
    reset_bench();
    lens[0] = 4; lens[1] = 4; lens[2] = 4; lens[3] = 4;
    make_frame(4, 1, 4, 2, 1'b0, 0);
    send_frame(4, 1);
    wait_count(exp_q.size());
    compare_frame("decim");
    check("decim p0", got_q.size() > 0 ? got_q[0] : 16'hxxxx, 16'd0);
    check("decim p1", got_q.size() > 1 ? got_q[1] : 16'hxxxx, 16'd2);
    check("decim p2", got_q.size() > 2 ? got_q[2] : 16'hxxxx, 16'd8);
    check("decim p3", got_q.size() > 3 ? got_q[3] : 16'hxxxx, 16'd10);
    check("decim frame_start", fs_cnt, 1);

    rnd_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      reset_bench();
      make_frame(4, 1, 4, 2, 1'b1, 0);
      send_frame(4, 1);
      wait_count(exp_q.size());
      compare_frame("rand b");
    end
    check("rand b size_err", size_err_b, 1'b0);
    check("rand b overflow", overflow_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
